// File: rtl/sseg_scan_reader.sv
// Recovers hex nibbles from a multiplexed, active-low seven-segment bus (segments + anodes).
// Decimal-point capture is enabled by defining SSEG_DP_CAPTURE_EN.
module sseg_scan_reader #(
    parameter int unsigned NUM_DIG    = 4,
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             seg_in,
    input  logic [NUM_DIG-1:0]     an_in,
    output logic [4*NUM_DIG-1:0]   value,
    output logic                   valid,
    output logic [NUM_DIG-1:0]     blank,
    output logic [NUM_DIG-1:0]     digit_err,
    output logic                   frame_err,
    output logic [NUM_DIG-1:0]     dp_out
);

    localparam int unsigned VW = 4 * NUM_DIG;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
`ifdef SSEG_DP_CAPTURE_EN
    localparam logic [7:0] SEG_CMP_MASK = 8'hFF;
    localparam logic       DP_EN        = 1'b1;
`else
    localparam logic [7:0] SEG_CMP_MASK = 8'h7F;
    localparam logic       DP_EN        = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    // Returns {err, blank, nibble}; inverse of the segment encoder table.
    function automatic logic [5:0] seg_decode(input logic [6:0] pat);
        logic [5:0] r;
        r = 6'b10_0000;
        case (pat)
            7'b1000000: r = 6'h00;
            7'b1111001: r = 6'h01;
            7'b0100100: r = 6'h02;
            7'b0110000: r = 6'h03;
            7'b0011001: r = 6'h04;
            7'b0010010: r = 6'h05;
            7'b0000010: r = 6'h06;
            7'b1111000: r = 6'h07;
            7'b0000000: r = 6'h08;
            7'b0011000: r = 6'h09;
            7'b0001000: r = 6'h0A;
            7'b0000011: r = 6'h0B;
            7'b1000110: r = 6'h0C;
            7'b0100001: r = 6'h0D;
            7'b0000110: r = 6'h0E;
            7'b0001110: r = 6'h0F;
            7'b1111111: r = 6'b01_0000;
            default:    r = 6'b10_0000;
        endcase
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_last_q, seg_last_d;
    logic [NUM_DIG-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_last_q, an_last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic [NUM_DIG-1:0]   mask_q, mask_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [VW-1:0]        stg_val_q, stg_val_d;
    logic [NUM_DIG-1:0]   stg_blank_q, stg_blank_d, stg_err_q, stg_err_d, stg_dp_q, stg_dp_d;
    logic [VW-1:0]        value_q, value_d;
    logic                 valid_q, valid_d, frame_err_q, frame_err_d;
    logic [NUM_DIG-1:0]   blank_q, blank_d, digit_err_q, digit_err_d, dp_q, dp_d;

    logic                 cap_c, full_c, tmo_hit_c, dp_c;
    logic [NUM_DIG-1:0]   sel_c, base_mask_c;
    logic [5:0]           dec_c;

    // Synchronizers and stability counter; a capture fires once when the count first saturates.
    always_comb begin
        seg_s1_d   = seg_in;
        seg_s2_d   = seg_s1_q;
        seg_last_d = seg_s2_q;
        an_s1_d    = an_in;
        an_s2_d    = an_s1_q;
        an_last_d  = an_s2_q;
        sat_d      = (cnt_q == CW'(STABLE_CNT));
        cnt_d      = cnt_q;
        if (!$onehot(~an_s2_q)) begin
            cnt_d = '0;
        end else if ((((seg_s2_q ^ seg_last_q) & SEG_CMP_MASK) != 8'h00) ||
                     (an_s2_q != an_last_q)) begin
            cnt_d = CW'(1);
        end else if (cnt_q < CW'(STABLE_CNT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // last_s2 holds the value that was counted stable when a capture fires.
    always_comb begin
        cap_c       = (cnt_q == CW'(STABLE_CNT)) && !sat_q;
        sel_c       = cap_c ? ~an_last_q : '0;
        dec_c       = seg_decode(seg_last_q[6:0]);
        dp_c        = DP_EN & ~seg_last_q[7];
        base_mask_c = (state_q == ST_PUBLISH) ? '0 : mask_q;
        full_c      = cap_c && ((base_mask_c | sel_c) == {NUM_DIG{1'b1}});
        tmo_hit_c   = (state_q == ST_COLLECT) && !cap_c && (tmo_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_c) state_d = full_c ? ST_PUBLISH : ST_COLLECT;
            end
            ST_COLLECT: begin
                if (full_c)         state_d = ST_PUBLISH;
                else if (tmo_hit_c) state_d = ST_IDLE;
            end
            ST_PUBLISH: begin
                if (cap_c) state_d = full_c ? ST_PUBLISH : ST_COLLECT;
                else       state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Staging, mask, timeout and published outputs.
    always_comb begin
        stg_val_d   = stg_val_q;
        stg_blank_d = stg_blank_q;
        stg_err_d   = stg_err_q;
        stg_dp_d    = stg_dp_q;
        value_d     = value_q;
        blank_d     = blank_q;
        digit_err_d = digit_err_q;
        dp_d        = dp_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        mask_d      = base_mask_c | sel_c;
        tmo_d       = '0;

        for (int i = 0; i < NUM_DIG; i++) begin
            if (sel_c[i]) begin
                stg_val_d[4*i +: 4] = dec_c[3:0];
                stg_blank_d[i]      = dec_c[4];
                stg_err_d[i]        = dec_c[5];
                stg_dp_d[i]         = dp_c;
            end
        end

        if (state_q == ST_COLLECT && !cap_c && !tmo_hit_c) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (tmo_hit_c) begin
            frame_err_d = 1'b1;
            mask_d      = '0;
        end

        if (state_q == ST_PUBLISH) begin
            value_d     = stg_val_q;
            blank_d     = stg_blank_q;
            digit_err_d = stg_err_q;
            dp_d        = stg_dp_q;
            valid_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q    <= '1;
            seg_s2_q    <= '1;
            seg_last_q  <= '1;
            an_s1_q     <= '1;
            an_s2_q     <= '1;
            an_last_q   <= '1;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            mask_q      <= '0;
            tmo_q       <= '0;
            stg_val_q   <= '0;
            stg_blank_q <= '0;
            stg_err_q   <= '0;
            stg_dp_q    <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            blank_q     <= '0;
            digit_err_q <= '0;
            frame_err_q <= 1'b0;
            dp_q        <= '0;
        end else begin
            seg_s1_q    <= seg_s1_d;
            seg_s2_q    <= seg_s2_d;
            seg_last_q  <= seg_last_d;
            an_s1_q     <= an_s1_d;
            an_s2_q     <= an_s2_d;
            an_last_q   <= an_last_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            mask_q      <= mask_d;
            tmo_q       <= tmo_d;
            stg_val_q   <= stg_val_d;
            stg_blank_q <= stg_blank_d;
            stg_err_q   <= stg_err_d;
            stg_dp_q    <= stg_dp_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            blank_q     <= blank_d;
            digit_err_q <= digit_err_d;
            frame_err_q <= frame_err_d;
            dp_q        <= dp_d;
        end
    end

    assign value     = value_q;
    assign valid     = valid_q;
    assign blank     = blank_q;
    assign digit_err = digit_err_q;
    assign frame_err = frame_err_q;
    assign dp_out    = dp_q;

endmodule

// File: tb/tb_sseg_scan_reader.sv
// Randomized self-checking bench for sseg_scan_reader against a frame-level reference model.
module tb_sseg_scan_reader;

    localparam int unsigned NUM_DIG    = 4;
    localparam int unsigned STABLE_CNT = 3;
    localparam int unsigned TIMEOUT    = 64;
`ifdef SSEG_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  e;
        logic [3:0]  d;
    } frame_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  an_in  = 4'hF;
    logic [15:0] value;
    logic        valid;
    logic [3:0]  blank;
    logic [3:0]  digit_err;
    logic        frame_err;
    logic [3:0]  dp_out;

    int checks = 0;
    int errors = 0;

    frame_t obs_q[$];
    frame_t exp_q[$];
    int     obs_ferr = 0;
    int     exp_ferr = 0;

    logic [3:0] mdl_mask  = 4'h0;
    frame_t     mdl_stage = '0;
    frame_t     last_pub  = '0;

    logic [6:0] pat_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    sseg_scan_reader #(
        .NUM_DIG   (NUM_DIG),
        .STABLE_CNT(STABLE_CNT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_in   (seg_in),
        .an_in    (an_in),
        .value    (value),
        .valid    (valid),
        .blank    (blank),
        .digit_err(digit_err),
        .frame_err(frame_err),
        .dp_out   (dp_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid)     obs_q.push_back(frame_t'({value, blank, digit_err, dp_out}));
            if (frame_err) obs_ferr++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Model decode: search the encoder table; {err, blank, nibble}.
    function automatic logic [5:0] mdl_decode(input logic [6:0] p);
        for (int n = 0; n < 16; n++) begin
            if (pat_tab[n] == p) return {2'b00, 4'(n)};
        end
        if (p == 7'h7F) return 6'b01_0000;
        return 6'b10_0000;
    endfunction

    function automatic logic [7:0] hexpat(input logic [3:0] n, input logic dp_lit);
        return {~dp_lit, pat_tab[n]};
    endfunction

    task automatic model_capture(input int d, input logic [7:0] seg);
        logic [5:0] r;
        r = mdl_decode(seg[6:0]);
        mdl_stage.v[4*d +: 4] = r[3:0];
        mdl_stage.b[d]        = r[4];
        mdl_stage.e[d]        = r[5];
        mdl_stage.d[d]        = DP_EN && !seg[7];
        mdl_mask[d]           = 1'b1;
        if (mdl_mask == 4'hF) begin
            exp_q.push_back(mdl_stage);
            last_pub = mdl_stage;
            mdl_mask = 4'h0;
        end
    endtask

    // Drive one digit for `dwell` cycles followed by an all-off gap.
    task automatic show(input int d, input logic [7:0] seg, input int dwell, input int gap);
        @(negedge clk);
        an_in  = ~(4'b0001 << d);
        seg_in = seg;
        repeat (dwell - 1) @(negedge clk);
        @(negedge clk);
        an_in  = 4'hF;
        seg_in = 8'hFF;
        repeat (gap - 1) @(negedge clk);
        if (dwell >= int'(STABLE_CNT)) model_capture(d, seg);
    endtask

    task automatic idle(input int n);
        an_in  = 4'hF;
        seg_in = 8'hFF;
        repeat (n) @(negedge clk);
        if (n > int'(TIMEOUT) + 10 && mdl_mask != 4'h0) begin
            exp_ferr++;
            mdl_mask = 4'h0;
        end
    endtask

    task automatic scan(input logic [15:0] v, input logic [3:0] dp_lit);
        for (int d = 3; d >= 0; d--) show(d, hexpat(v[4*d +: 4], dp_lit[d]), 8, 2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (value !== 16'h0)     begin errors++; $display("FAIL reset_value got %h exp 0000", value); end
        checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (blank !== 4'h0)      begin errors++; $display("FAIL reset_blank got %b exp 0000", blank); end
        checks++; if (digit_err !== 4'h0)  begin errors++; $display("FAIL reset_digit_err got %b exp 0000", digit_err); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (dp_out !== 4'h0)     begin errors++; $display("FAIL reset_dp got %b exp 0000", dp_out); end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        frame_t got, exp;
        scan(16'h3A5F, 4'h0);
        idle(12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL basic_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_frame got %h exp %h", got, exp); end
        end
        obs_q.delete(); exp_q.delete();
        checks++; if (value !== 16'h3A5F) begin errors++; $display("FAIL basic_value got %h exp 3a5f", value); end
        checks++; if (blank !== 4'h0)     begin errors++; $display("FAIL basic_blank got %b exp 0000", blank); end
        checks++; if (digit_err !== 4'h0) begin errors++; $display("FAIL basic_err got %b exp 0000", digit_err); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL basic_valid_hold got %b exp 0", valid); end
    endtask

    task automatic test_short_dwell();
        frame_t got, exp;
        show(3, hexpat(4'h1, 1'b0), 8, 2);
        show(2, hexpat(4'h2, 1'b0), 8, 2);
        show(1, hexpat(4'h9, 1'b0), 2, 2);
        show(0, hexpat(4'h4, 1'b0), 8, 2);
        idle(10);
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL short_novalid got %0d exp 0", obs_q.size()); end
        checks++; if (obs_ferr !== exp_ferr) begin errors++; $display("FAIL short_noferr got %0d exp %0d", obs_ferr, exp_ferr); end
        show(1, hexpat(4'h9, 1'b0), 3, 2);
        idle(12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL short_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL short_frame got %h exp %h", got, exp); end
        end
        obs_q.delete(); exp_q.delete();
        checks++; if (value !== 16'h1294) begin errors++; $display("FAIL short_value got %h exp 1294", value); end
    endtask

    task automatic test_blank_err();
        frame_t got, exp;
        show(3, hexpat(4'h7, 1'b0), 8, 2);
        show(2, 8'hFF, 8, 2);
        show(1, hexpat(4'hB, 1'b0), 8, 2);
        show(0, 8'hAA, 8, 2);
        idle(12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL blankerr_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL blankerr_frame got %h exp %h", got, exp); end
        end
        obs_q.delete(); exp_q.delete();
        checks++; if (value !== 16'h70B0)     begin errors++; $display("FAIL blankerr_value got %h exp 70b0", value); end
        checks++; if (blank !== 4'b0100)      begin errors++; $display("FAIL blankerr_blank got %b exp 0100", blank); end
        checks++; if (digit_err !== 4'b0001)  begin errors++; $display("FAIL blankerr_err got %b exp 0001", digit_err); end
    endtask

    task automatic test_timeout();
        int ferr0;
        ferr0 = obs_ferr;
        show(0, hexpat(4'h6, 1'b0), 8, 2);
        show(1, hexpat(4'hC, 1'b0), 8, 2);
        idle(int'(TIMEOUT) + 30);
        checks++; if (obs_ferr !== exp_ferr)  begin errors++; $display("FAIL tmo_ferr_model got %0d exp %0d", obs_ferr, exp_ferr); end
        checks++; if (obs_ferr - ferr0 !== 1) begin errors++; $display("FAIL tmo_ferr_once got %0d exp 1", obs_ferr - ferr0); end
        checks++; if (obs_q.size() !== 0)     begin errors++; $display("FAIL tmo_novalid got %0d exp 0", obs_q.size()); end
        checks++; if (value !== last_pub.v)   begin errors++; $display("FAIL tmo_value_hold got %h exp %h", value, last_pub.v); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        frame_t got, exp;
        show(3, hexpat(4'hE, 1'b0), 8, 2);
        show(2, hexpat(4'hD, 1'b0), 8, 2);
        show(1, hexpat(4'h8, 1'b0), 8, 2);
        idle(2);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mdl_mask = 4'h0; mdl_stage = '0; last_pub = '0;
        checks++; if (value !== 16'h0) begin errors++; $display("FAIL rstmid_value got %h exp 0000", value); end
        idle(3);
        scan(16'h1234, 4'h0);
        idle(12);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL rstmid_count got %0d exp 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL rstmid_frame got %h exp %h", got, exp); end
        end
        obs_q.delete(); exp_q.delete();
        checks++; if (value !== 16'h1234) begin errors++; $display("FAIL rstmid_final got %h exp 1234", value); end
    endtask

    task automatic test_dp();
        frame_t got, exp;
        scan(16'h3A5F, 4'b1000);
        idle(12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL dp_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL dp_frame got %h exp %h", got, exp); end
        end
        obs_q.delete(); exp_q.delete();
        checks++; if (dp_out !== (DP_EN ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL dp_out got %b exp %b", dp_out, DP_EN ? 4'b1000 : 4'b0000); end
        checks++; if (value !== 16'h3A5F) begin errors++; $display("FAIL dp_value got %h exp 3a5f", value); end
    endtask

    task automatic test_random();
        frame_t     got, exp;
        int         miss;
        int         d, kind, dwell;
        logic [7:0] seg;
        miss = 0;
        for (int k = 0; k < 80; k++) begin
            d    = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            if (kind < 8)       seg = hexpat(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else if (kind == 8) seg = {1'($urandom_range(0, 1)), 7'h7F};
            else                seg = 8'($urandom_range(0, 255));
            if (miss < 2 && $urandom_range(0, 4) == 0) begin
                dwell = 2; miss++;
            end else begin
                dwell = int'($urandom_range(3, 8)); miss = 0;
            end
            show(d, seg, dwell, int'($urandom_range(1, 4)));
        end
        idle(12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL rand_frame got %h exp %h", got, exp); end
        end
        obs_q.delete(); exp_q.delete();
        idle(int'(TIMEOUT) + 30);
        checks++; if (obs_ferr !== exp_ferr) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", obs_ferr, exp_ferr); end
        checks++; if (value !== last_pub.v) begin errors++; $display("FAIL rand_value_hold got %h exp %h", value, last_pub.v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_dwell();
        test_blank_err();
        test_timeout();
        test_reset_mid();
        test_dp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_reader.md
Name: sseg_scan_reader

Overview:
- Reads a multiplexed, active-low seven-segment display bus (segment lines plus digit anodes) and recovers the hex nibble shown on each digit.
- It is the receive side of the team's segment decoder: segment patterns in, binary out.
- Used as a loopback checker on the board display bus and for reading external scanned displays.
- Per-digit stability filtering, frame assembly, invalid-pattern flagging and a scan timeout are included.

Parameters:
- NUM_DIG, 4, number of multiplexed digits / anode lines.
- STABLE_CNT, 3, consecutive identical synchronized samples required to accept a digit (range 2..15).
- TIMEOUT, 1000000, cycles without a capture before a partial frame is abandoned.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  8  segment bus, active low; [6:0] = g,f,e,d,c,b,a; [7] = dp.
- an_in  input  NUM_DIG  anode selects, active low, one-hot-low when a digit is driven.
- value  output  4*NUM_DIG  assembled frame; digit i in bits [4i+3:4i].
- valid  output  1  one-cycle pulse when value/blank/digit_err update.
- blank  output  NUM_DIG  digit showed all segments off (pattern 1111111).
- digit_err  output  NUM_DIG  digit pattern not in the 16-entry table and not blank.
- frame_err  output  1  one-cycle pulse on timeout of a partial frame.
- dp_out  output  NUM_DIG  decimal-point capture (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): value=0, valid=0, blank=0, digit_err=0, frame_err=0, dp_out=0, capture mask=0, stability counter=0, timeout counter=0, state=IDLE. Synchronizers clear to all-ones (display off).
- Input sync: seg_in and an_in pass through 2-flop synchronizers (s1, s2). last_s2 holds the previous s2.
- Stability counter:
  - s2 != last_s2: cnt loads 1.
  - s2 == last_s2: cnt increments, saturating at STABLE_CNT.
  - an(s2) not exactly one low bit (blanking gap, all high, multi-low): cnt forced to 0 and no capture.
- Capture: one capture on the cycle cnt transitions to STABLE_CNT; none while it stays saturated.
  - Capture registers land on edge STABLE_CNT+3, counted from the first edge the pins hold the new value.
  - Decode, exact inverse of the team table:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0011000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111 gives nibble 0 with blank bit set. Any other pattern gives nibble 0 with digit_err bit set.
  - The selected digit's staging slot is written and its mask bit is set. Re-capturing an already-set digit overwrites the slot.
- States:
  - IDLE (mask=0): first capture goes to COLLECT.
  - COLLECT: when mask becomes all-ones, go to PUBLISH.
  - PUBLISH (one cycle): copy staging to value/blank/digit_err/dp_out, pulse valid, clear mask, go to IDLE.
    - valid is high on edge N+1, where N is the completing capture edge.
    - A capture arriving in the PUBLISH cycle is applied to the fresh (cleared) mask.
- Timeout: counter increments each cycle in COLLECT and clears on any capture.
  - At TIMEOUT: pulse frame_err, clear mask, go to IDLE. value is unchanged.
  - If timeout and capture occur in the same cycle, the capture wins.
- Outputs hold between valid pulses.
- Reset mid-frame discards all partial state. There is no valid pulse until a complete new frame is captured.

Optional Feature:
- Macro SSEG_DP_CAPTURE_EN.
- Defined: seg_in[7] is decoded per digit (0 means dp lit, giving dp_out bit 1). It is staged and published with the frame, and included in the stability comparison.
- Undefined: seg_in[7] is ignored entirely, including in the stability comparison. dp_out is tied to 0.

Test Plan:
- Scan 0x3A5F (digit3..0), each digit held 8 cycles, with 2-cycle all-high gaps -> valid pulses once; value=16'h3A5F, blank=0, digit_err=0.
- Digit 1 held only 2 cycles (STABLE_CNT=3), remainder normal -> no valid until a later full dwell on digit 1; no frame_err before TIMEOUT.
- Digit 2 drives 1111111, digit 0 drives 0101010 -> value nibbles 2 and 0 are 0; blank=4'b0100; digit_err=4'b0001.
- Capture digits 0 and 1 only, then an_in=all-high for TIMEOUT cycles (TIMEOUT=64 in bench) -> frame_err pulses exactly once; valid stays 0; value keeps its previous frame.
- rst_n low for 1 cycle after 3 digits are captured, then a full scan of 0x1234 -> exactly one valid, value=16'h1234.
- With SSEG_DP_CAPTURE_EN: seg_in[7]=0 on digit 3 only -> dp_out=4'b1000. Without the macro -> dp_out=0, and value is the same.
